gain_ramp_sequencer: RTL
========================

// Module: gain_ramp_sequencer
// PURPOSE
//  AXI4-Lite master that drives the 4 gain registers of gain_config (offsets 0x0/0x4/0x8/0xC).
//  Users post per-channel target gains. Each step tick, every channel whose current value differs
//  from its target moves one step of at most STEP toward it, so gain changes never jump (no zipper noise).
//  Channels are served round-robin; each step is one AXI4-Lite single write. Sits between the control
//  logic and the gain_config slave port.
// PARAMETERS
//  NUM_CH     4           channels / gain registers (1..4)
//  GAIN_W     32          gain register width; equals AXI data width
//  STEP       32'h100     max change per step, unsigned
//  TICK_DIV   48000       ACLK cycles between step ticks (>=8)
//  BASE_ADDR  32'h0       gain_config base address; chan n at BASE_ADDR+4*n
// PORTS
//  ACLK           in   1       clock
//  ARESET         in   1       synchronous, active-high reset
//  tgt_valid      in   1       target update request
//  tgt_ready      out  1       always 1 outside reset; update accepted on valid&ready
//  tgt_chan       in   2       channel of target update
//  tgt_gain       in   GAIN_W  new target gain
//  busy           out  1       FSM not IDLE
//  err            out  1       sticky: non-OKAY BRESP/RRESP or readback mismatch
//  err_clr        in   1       clears err (set wins if same cycle)
//  m_axi_aw*      out  32/3/1  awaddr, awprot(=0), awvalid; awready in
//  m_axi_w*       out  32/4/1  wdata, wstrb(=4'hF), wvalid; wready in
//  m_axi_b*       in   2/1     bresp, bvalid; bready out
//  m_axi_ar*/r*   out/in       araddr, arprot, arvalid/arready; rdata, rresp, rvalid/rready
// BEHAVIOUR
//  - Reset: tgt[]=cur[]=0, all AXI valids/readies 0, busy=0, err=0, tick counter=TICK_DIV-1, RR pointer=0.
//  - tgt_ready=0 in reset cycle, else 1. Accepted update overwrites tgt[chan] next edge. An update to a
//    channel mid-write does not alter the in-flight beat; it applies from the next step.
//  - Tick: counter decrements each cycle, pulses at 0 and reloads. A tick while busy sets tick_pend
//    (single bit, saturates, never counts more). IDLE consumes tick or tick_pend.
//  - FSM: IDLE -(tick & any cur!=tgt)-> SCAN: latch pending mask = {cur!=tgt}. SCAN: RR pick from
//    pointer, compute step -> WR. WR: awvalid & wvalid asserted together, each drops independently on its
//    handshake -> RESP when both done. RESP: bready=1 -> next mask bit (SCAN) or IDLE when mask empty.
//    Pointer = granted chan+1 mod NUM_CH.
//  - Step: up: next = (tgt-cur > STEP) ? cur+STEP : tgt; down is symmetric. Unsigned, no wrap, never overshoots.
//  - BRESP==OKAY: cur[chan]<=next on B handshake. Otherwise err<=1 and cur unchanged (retried next tick).
//  - Latency: tick edge -> awvalid high 2 cycles later (SCAN 1 cycle).
//  - Mask empty at tick (all settled): stay IDLE, no AXI traffic.
//  - Reset mid-burst: valids low the next edge, FSM IDLE; the interconnect shares ARESET.
// CONFIGURATION
//  GAIN_RAMP_READBACK_EN defined: RESP -> RD (arvalid, araddr=same) -> RRESP (rready=1). rdata!=next or
//    rresp!=OKAY sets err. Otherwise mask advances. cur is already updated on B.
//  Undefined: AR/R ports tied off (arvalid=0, rready=0, araddr=0), RD/RRESP states absent.
// STRUCTURE
//  gain_ramp_pkg: state enum (IDLE,SCAN,WR,RESP,RD,RRESP), AXI_RESP_OKAY=2'b00, CH_W=2, addr helper fn.
//  Sub-module gain_ramp_rr_arb: NUM_CH round-robin arbiter (mask, pointer -> one-hot grant, valid).
// TESTING
//  1 Reset, tgt ch0=0x250, STEP=0x100 -> writes 0x100, 0x200, 0x250 to addr 0x0 on 3 ticks, then idle.
//  2 tgt ch1=0x300, ch3=0x100 in same tick window -> ch1 then ch3 per tick, RR order kept.
//  3 cur ch2=0x500, tgt=0x480 -> single write 0x480 (no overshoot); tgt=0 later -> 0x380..0x080, 0.
//  4 Slave holds awready 5 cycles and wready 1 cycle -> each valid stays up until its own handshake,
//    one B accepted, no duplicate beat.
//  5 Slave returns BRESP=SLVERR once -> err=1, cur unchanged, same value rewritten next tick. err_clr -> 0.
//  6 ARESET asserted while in WR -> awvalid/wvalid 0 next edge, cur/tgt 0, busy 0. With
//    GAIN_RAMP_READBACK_EN: slave corrupts rdata -> err=1.

Source files
------------

// File: rtl/gain_ramp_pkg.sv
// Shared types and helpers for the gain ramp sequencer (AXI4-Lite master into gain_config).
package gain_ramp_pkg;

  localparam int unsigned CH_W = 2;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_WR    = 3'd2,
    ST_RESP  = 3'd3,
    ST_RD    = 3'd4,
    ST_RRESP = 3'd5
  } state_e;

  // Gain registers sit on a 4-byte stride from the gain_config base.
  function automatic logic [31:0] chan_addr(input logic [31:0] base, input logic [CH_W-1:0] ch);
    return base + {28'd0, ch, 2'b00};
  endfunction

endpackage

// File: rtl/gain_ramp_sequencer_rr_arb.sv
// Round-robin arbiter: first set mask bit at or after the pointer wins (one-hot grant plus index).
module gain_ramp_rr_arb
  import gain_ramp_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              valid
);

  logic [CH_W-1:0] ch;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    ch        = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch = CH_W'((32'(ptr) + i) % NUM_CH);
      if (!valid && mask[ch]) begin
        valid     = 1'b1;
        grant[ch] = 1'b1;
        grant_idx = ch;
      end
    end
  end

endmodule

// File: rtl/gain_ramp_sequencer.sv
// Steps per-channel gains toward their targets via AXI4-Lite single writes, round-robin per tick.
// Optional readback verification after each write: define GAIN_RAMP_READBACK_EN.
module gain_ramp_sequencer
  import gain_ramp_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned GAIN_W    = 32,
  parameter logic [31:0] STEP      = 32'h100,
  parameter int unsigned TICK_DIV  = 48000,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [CH_W-1:0]   tgt_chan,
  input  logic [GAIN_W-1:0] tgt_gain,
  output logic              busy,
  output logic              err,
  input  logic              err_clr,
  output logic [31:0]       m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [GAIN_W-1:0] m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [31:0]       m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [GAIN_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  state_e              state_q, state_d, after_step;
  logic [31:0]         tick_cnt_q, tick_cnt_d;
  logic                tick_pend_q, tick_pend_d, tick;
  logic [NUM_CH-1:0]   mask_q, mask_d, pend_vec;
  logic [CH_W-1:0]     ptr_q, ptr_d, ch_q, ch_d;
  logic [GAIN_W-1:0]   next_q, next_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                err_q, err_d, err_set;
  logic [GAIN_W-1:0]   cur_q [NUM_CH];
  logic [GAIN_W-1:0]   cur_d [NUM_CH];
  logic [GAIN_W-1:0]   tgt_q [NUM_CH];
  logic [GAIN_W-1:0]   tgt_d [NUM_CH];
  logic [NUM_CH-1:0]   arb_grant;
  logic [CH_W-1:0]     arb_idx;
  logic                arb_valid;
`ifdef GAIN_RAMP_READBACK_EN
  logic                arvalid_q, arvalid_d, rready_q, rready_d;
`endif

  // Move at most STEP toward the target; the clamp to t means no overshoot and no wrap.
  function automatic logic [GAIN_W-1:0] step_toward(input logic [GAIN_W-1:0] c,
                                                    input logic [GAIN_W-1:0] t);
    logic [GAIN_W-1:0] s;
    s = GAIN_W'(STEP);
    if (t > c) return (t - c > s) ? c + s : t;
    if (c > t) return (c - t > s) ? c - s : t;
    return c;
  endfunction

  gain_ramp_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .mask      (mask_q),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  assign tick       = (tick_cnt_q == 32'd0);
  assign after_step = (|mask_q) ? ST_SCAN : ST_IDLE;

  always_comb begin
    pend_vec = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) pend_vec[i] = (cur_q[i] != tgt_q[i]);
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? 32'(TICK_DIV - 1) : tick_cnt_q - 32'd1;
    tick_pend_d = tick_pend_q | (tick && (state_q != ST_IDLE));
    mask_d      = mask_q;
    ptr_d       = ptr_q;
    ch_d        = ch_q;
    next_d      = next_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    err_set     = 1'b0;
    cur_d       = cur_q;
    tgt_d       = tgt_q;
`ifdef GAIN_RAMP_READBACK_EN
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
`endif
    // Target updates land in tgt only; an in-flight beat keeps its latched next_q.
    if (tgt_valid && tgt_ready && (32'(tgt_chan) < NUM_CH)) tgt_d[tgt_chan] = tgt_gain;

    case (state_q)
      ST_IDLE: begin
        if (tick || tick_pend_q) begin
          tick_pend_d = 1'b0;
          if (|pend_vec) begin
            mask_d  = pend_vec;
            state_d = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (arb_valid) begin
          ch_d      = arb_idx;
          next_d    = step_toward(cur_q[arb_idx], tgt_q[arb_idx]);
          mask_d    = mask_q & ~arb_grant;
          ptr_d     = (32'(arb_idx) == NUM_CH - 1) ? '0 : arb_idx + CH_W'(1);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ST_WR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        awvalid_d = awvalid_q & ~m_axi_awready;
        wvalid_d  = wvalid_q & ~m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          if (m_axi_bresp == AXI_RESP_OKAY) begin
            cur_d[ch_q] = next_q;
`ifdef GAIN_RAMP_READBACK_EN
            arvalid_d   = 1'b1;
            state_d     = ST_RD;
`else
            state_d     = after_step;
`endif
          end else begin
            err_set = 1'b1;
            state_d = after_step;
          end
        end
      end
`ifdef GAIN_RAMP_READBACK_EN
      ST_RD: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RRESP;
        end
      end
      ST_RRESP: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rdata != next_q)) err_set = 1'b1;
          state_d = after_step;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    err_d = err_clr ? 1'b0 : err_q;
    if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= 32'(TICK_DIV - 1);
      tick_pend_q <= 1'b0;
      mask_q      <= '0;
      ptr_q       <= '0;
      ch_q        <= '0;
      next_q      <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cur_q[i] <= '0;
        tgt_q[i] <= '0;
      end
`ifdef GAIN_RAMP_READBACK_EN
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      tick_pend_q <= tick_pend_d;
      mask_q      <= mask_d;
      ptr_q       <= ptr_d;
      ch_q        <= ch_d;
      next_q      <= next_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      err_q       <= err_d;
      cur_q       <= cur_d;
      tgt_q       <= tgt_d;
`ifdef GAIN_RAMP_READBACK_EN
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
`endif
    end
  end

  assign tgt_ready     = ~ARESET;
  assign busy          = (state_q != ST_IDLE);
  assign err           = err_q;
  assign m_axi_awaddr  = chan_addr(BASE_ADDR, ch_q);
  assign m_axi_awprot  = '0;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = next_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arprot  = '0;
`ifdef GAIN_RAMP_READBACK_EN
  assign m_axi_araddr  = m_axi_awaddr;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
`else
  logic unused_rd_sink;
  assign unused_rd_sink = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};
  assign m_axi_araddr  = '0;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;
`endif

endmodule
